// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin denomination encoding, coin values
// and the change dispenser state type.
package vm_pkg;

   localparam logic [1:0] DEN_1  = 2'd0;
   localparam logic [1:0] DEN_5  = 2'd1;
   localparam logic [1:0] DEN_10 = 2'd2;
   localparam logic [1:0] DEN_50 = 2'd3;

   localparam int VAL_1  = 1;
   localparam int VAL_5  = 5;
   localparam int VAL_10 = 10;
   localparam int VAL_50 = 50;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_EJECT  = 3'd2,
      ST_DONE   = 3'd3,
      ST_FAULT  = 3'd4
   } state_e;

endpackage

// File: rtl/coin_stock.sv
// Four per-denomination coin counters with saturating load, single-coin
// decrement and an empty flag per counter.
module coin_stock
   import vm_pkg::*;
#(
   parameter int STOCK_W    = 8,
   parameter int INIT_STOCK = 20
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load_en_i,
   input  logic [1:0]               load_sel_i,
   input  logic [STOCK_W-1:0]       load_count_i,
   input  logic                     dec_en_i,
   input  logic [1:0]               dec_sel_i,
   output logic [3:0][STOCK_W-1:0]  stock_o,
   output logic [3:0]               stock_empty_o
);

   localparam logic [STOCK_W:0] MAX_CNT = {1'b0, {STOCK_W{1'b1}}};

   logic [3:0][STOCK_W-1:0] stock_q, stock_d;
   logic [3:0][STOCK_W:0]   sum;

   // One extra bit of headroom lets load and decrement net out before saturating.
   always_comb begin
      sum     = '0;
      stock_d = stock_q;
      for (int i = 0; i < 4; i++) begin
         sum[i] = {1'b0, stock_q[i]};
         if (load_en_i && (load_sel_i == 2'(i)))
            sum[i] = sum[i] + {1'b0, load_count_i};
         if (dec_en_i && (dec_sel_i == 2'(i)))
            sum[i] = sum[i] - {{STOCK_W{1'b0}}, 1'b1};
         stock_d[i] = (sum[i] > MAX_CNT) ? MAX_CNT[STOCK_W-1:0] : sum[i][STOCK_W-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 4; i++)
            stock_q[i] <= STOCK_W'(INIT_STOCK);
      end else begin
         stock_q <= stock_d;
      end
   end

   always_comb begin
      stock_empty_o = '0;
      for (int i = 0; i < 4; i++)
         stock_empty_o[i] = (stock_q[i] == '0);
   end

   assign stock_o = stock_q;

endmodule

// File: rtl/change_dispenser.sv
// Pays a refund out one coin at a time over a hopper handshake, greedy over
// 50/10/5/1, faulting with the unpaid remainder when stock runs short.
module change_dispenser
   import vm_pkg::*;
#(
   parameter int AMT_W      = 16,
   parameter int STOCK_W    = 8,
   parameter int INIT_STOCK = 20
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               amt_valid,
   input  logic [AMT_W-1:0]   amt_data,
   output logic               amt_ready,
   output logic               eject_valid,
   output logic [1:0]         eject_sel,
   input  logic               eject_ack,
   input  logic               load_en,
   input  logic [1:0]         load_sel,
   input  logic [STOCK_W-1:0] load_count,
   output logic [3:0]         stock_empty,
   output logic               busy,
   output logic               done,
   output logic               fault,
   output logic [AMT_W-1:0]   owed,
   input  logic               fault_clr
);

   state_e                  state_q, state_d;
   logic [AMT_W-1:0]        rem_q, rem_d;
   logic [1:0]              sel_q, sel_d;
   logic [3:0][STOCK_W-1:0] stock;
   logic                    dec_en;
   logic                    pick_ok;
   logic [1:0]              pick;

   function automatic logic [AMT_W-1:0] den_val(input logic [1:0] d);
      case (d)
         DEN_50:  return AMT_W'(VAL_50);
         DEN_10:  return AMT_W'(VAL_10);
         DEN_5:   return AMT_W'(VAL_5);
         default: return AMT_W'(VAL_1);
      endcase
   endfunction

   coin_stock #(
      .STOCK_W    (STOCK_W),
      .INIT_STOCK (INIT_STOCK)
   ) u_stock (
      .clock         (clock),
      .reset         (reset),
      .load_en_i     (load_en),
      .load_sel_i    (load_sel),
      .load_count_i  (load_count),
      .dec_en_i      (dec_en),
      .dec_sel_i     (sel_q),
      .stock_o       (stock),
      .stock_empty_o (stock_empty)
   );

   // Greedy pick: largest coin that fits the remainder and is still in stock.
   always_comb begin
      pick_ok = 1'b1;
      pick    = DEN_1;
      if ((rem_q >= den_val(DEN_50)) && (stock[DEN_50] != '0))
         pick = DEN_50;
      else if ((rem_q >= den_val(DEN_10)) && (stock[DEN_10] != '0))
         pick = DEN_10;
      else if ((rem_q >= den_val(DEN_5)) && (stock[DEN_5] != '0))
         pick = DEN_5;
      else if ((rem_q >= den_val(DEN_1)) && (stock[DEN_1] != '0))
         pick = DEN_1;
      else
         pick_ok = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      sel_d   = sel_q;
      dec_en  = 1'b0;
      case (state_q)
         // A zero refund still passes through SELECT, so done always lands
         // 2*N+2 cycles after acceptance.
         ST_IDLE: begin
            if (amt_valid) begin
               rem_d   = amt_data;
               state_d = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (rem_q == '0) begin
               state_d = ST_DONE;
            end else if (pick_ok) begin
               sel_d   = pick;
               state_d = ST_EJECT;
            end else begin
               state_d = ST_FAULT;
            end
         end
         ST_EJECT: begin
            if (eject_ack) begin
               rem_d   = rem_q - den_val(sel_q);
               dec_en  = 1'b1;
               state_d = ST_SELECT;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_FAULT: begin
            if (fault_clr) begin
               rem_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         sel_q   <= DEN_1;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sel_q   <= sel_d;
      end
   end

   assign amt_ready   = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign eject_valid = (state_q == ST_EJECT);
   assign eject_sel   = (state_q == ST_EJECT) ? sel_q : 2'd0;
   assign done        = (state_q == ST_DONE);
   assign fault       = (state_q == ST_FAULT);
   assign owed        = (state_q == ST_FAULT) ? rem_q : '0;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized checks of change_dispenser against a greedy payout
// model tracking stock and remainder at the coin level.
module tb_change_dispenser;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        amt_valid = 1'b0;
   logic [15:0] amt_data = '0;
   logic        amt_ready;
   logic        eject_valid;
   logic [1:0]  eject_sel;
   logic        eject_ack = 1'b0;
   logic        load_en = 1'b0;
   logic [1:0]  load_sel = '0;
   logic [7:0]  load_count = '0;
   logic [3:0]  stock_empty;
   logic        busy;
   logic        done;
   logic        fault;
   logic [15:0] owed;
   logic        fault_clr = 1'b0;

   int checks   = 0;
   int failures = 0;
   int mstock[4];
   int mrem;
   int got_owed;

   change_dispenser dut (
      .clock       (clock),
      .reset       (reset),
      .amt_valid   (amt_valid),
      .amt_data    (amt_data),
      .amt_ready   (amt_ready),
      .eject_valid (eject_valid),
      .eject_sel   (eject_sel),
      .eject_ack   (eject_ack),
      .load_en     (load_en),
      .load_sel    (load_sel),
      .load_count  (load_count),
      .stock_empty (stock_empty),
      .busy        (busy),
      .done        (done),
      .fault       (fault),
      .owed        (owed),
      .fault_clr   (fault_clr)
   );

   always #5 clock = ~clock;

   function automatic int vval(input int d);
      case (d)
         3: return 50;
         2: return 10;
         1: return 5;
         default: return 1;
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_stock(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_stock"}, 32'(dut.u_stock.stock_q[i]), mstock[i]);
         chk({tag, "_empty"}, 32'(stock_empty[i]), 32'(mstock[i] == 0));
      end
   endtask

   task automatic load(input int s, input int c);
      load_en = 1'b1; load_sel = s[1:0]; load_count = c[7:0];
      tick();
      load_en = 1'b0;
      mstock[s] = (mstock[s] + c > 255) ? 255 : mstock[s] + c;
      check_stock("load");
   endtask

   // Runs one refund; the model plans the greedy payout on a copy of the stock
   // and the DUT must eject exactly that coin list, then done or fault.
   task automatic refund(input int amt, input int mind, input int maxd, input bit tie,
                         output int obs_owed);
      int s[4];
      int r, exp_owed, lat, cyc, w, dly, d;
      int q[$];
      bit fin, sawf;
      s = mstock;
      r = amt;
      while (r > 0) begin
         d = -1;
         for (int k = 3; k >= 0; k--)
            if (d < 0 && vval(k) <= r && s[k] > 0) d = k;
         if (d < 0) break;
         q.push_back(d);
         s[d]--;
         r -= vval(d);
      end
      exp_owed = r;
      lat = 2 * q.size() + 2;
      obs_owed = 0; fin = 0; sawf = 0; w = 0;
      dly = $urandom_range(maxd, mind);
      amt_valid = 1'b1; amt_data = amt[15:0];
      chk("amt_ready_idle", 32'(amt_ready), 1);
      tick();
      amt_valid = 1'b0;
      mrem = amt;
      cyc = 1;
      chk("amt_ready_drop", 32'(amt_ready), 0);
      while (!fin && cyc < 4000) begin
         chk("rem", 32'(dut.rem_q), mrem);
         if (done) begin
            chk("done_expected", exp_owed, 0);
            chk("done_coins_left", q.size(), 0);
            if (tie) chk("done_latency", cyc, lat);
            fin = 1;
         end else if (fault) begin
            chk("owed", 32'(owed), exp_owed);
            chk("fault_coins_left", q.size(), 0);
            obs_owed = owed;
            sawf = 1;
            fin = 1;
         end else begin
            eject_ack = tie;
            if (eject_valid) begin
               if (q.size() == 0) begin
                  chk("extra_eject", 32'(eject_valid), 0);
               end else begin
                  chk("eject_sel", 32'(eject_sel), q[0]);
                  if (tie || w >= dly) begin
                     eject_ack = 1'b1;
                     mstock[q[0]]--;
                     mrem -= vval(q[0]);
                     void'(q.pop_front());
                     w = 0;
                     dly = $urandom_range(maxd, mind);
                  end else begin
                     w++;
                  end
               end
            end
            tick();
            cyc++;
         end
      end
      eject_ack = 1'b0;
      chk("no_timeout", 32'(fin), 1);
      if (fin && sawf) begin
         chk("busy_fault", 32'(busy), 1);
         fault_clr = 1'b1;
         tick();
         fault_clr = 1'b0;
         mrem = 0;
         chk("fault_clr", 32'(fault), 0);
         chk("owed_clr", 32'(owed), 0);
         chk("idle_after_clr", 32'(amt_ready), 1);
         chk("rem_clr", 32'(dut.rem_q), 0);
      end else if (fin) begin
         tick();
         chk("done_pulse", 32'(done), 0);
         chk("idle_after_done", 32'(amt_ready), 1);
      end
      check_stock("post");
   endtask

   initial begin
      for (int i = 0; i < 4; i++) mstock[i] = 20;
      mrem = 0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      chk("rst_eject_valid", 32'(eject_valid), 0);
      chk("rst_eject_sel", 32'(eject_sel), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_owed", 32'(owed), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(amt_ready), 1);
      check_stock("rst");

      // Refund 35 with ack tied high: 10,10,10,5 and done at cycle 10
      refund(35, 0, 0, 1'b1, got_owed);
      chk("r35_stock10", 32'(dut.u_stock.stock_q[2]), 17);
      chk("r35_stock5", 32'(dut.u_stock.stock_q[1]), 19);

      // Zero refund: done 2 cycles after acceptance, no eject
      refund(0, 0, 0, 1'b1, got_owed);

      // Ack arriving 3 cycles late
      refund(7, 3, 3, 1'b0, got_owed);

      // Empty the 50s and 10s, then pay 60 in 5s
      for (int i = 0; i < 20; i++) refund(50, 0, 2, 1'b0, got_owed);
      while (mstock[2] > 0) refund(10, 0, 2, 1'b0, got_owed);
      refund(60, 0, 1, 1'b0, got_owed);
      while (mstock[1] > 3) refund(5, 0, 1, 1'b0, got_owed);
      while (mstock[0] > 2) refund(1, 0, 1, 1'b0, got_owed);
      // 3x5 + 2x1 paid, 43 owed
      refund(60, 0, 2, 1'b0, got_owed);
      chk("fault_owed_43", got_owed, 43);

      // Same-cycle load and eject on the 10s counter
      load(2, 1);
      amt_valid = 1'b1; amt_data = 16'd10;
      tick();
      amt_valid = 1'b0;
      tick();
      chk("sc_eject_valid", 32'(eject_valid), 1);
      chk("sc_eject_sel", 32'(eject_sel), 2);
      eject_ack = 1'b1; load_en = 1'b1; load_sel = 2'd2; load_count = 8'd4;
      tick();
      eject_ack = 1'b0; load_en = 1'b0;
      mstock[2] = 4;
      chk("sc_stock10", 32'(dut.u_stock.stock_q[2]), 4);
      tick();
      chk("sc_done", 32'(done), 1);
      tick();
      chk("sc_idle", 32'(amt_ready), 1);
      check_stock("sc");

      // Saturation
      load(0, 250);
      load(0, 10);
      chk("sat_255", 32'(dut.u_stock.stock_q[0]), 255);

      // Reset in the middle of EJECT
      amt_valid = 1'b1; amt_data = 16'd35;
      tick();
      amt_valid = 1'b0;
      tick();
      chk("mr_eject_valid", 32'(eject_valid), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) mstock[i] = 20;
      mrem = 0;
      chk("mr_ready", 32'(amt_ready), 1);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_eject_valid_low", 32'(eject_valid), 0);
      chk("mr_rem", 32'(dut.rem_q), 0);
      check_stock("mr");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("mr_no_done", 32'(done), 0);
      end

      // Randomized loads and refunds
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(2, 0) == 0)
            load(int'($urandom_range(3, 0)), int'($urandom_range(40, 0)));
         refund(int'($urandom_range(400, 0)), 0, 2, 1'($urandom_range(1, 0)), got_owed);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

endmodule
